// File: rtl/player_shot.sv
// player_shot: player projectile slots with fire synchronizer, per-frame motion,
// hit-driven retirement and a frame-stable raster overlay for the video mixer.
module player_shot #(
  parameter int          NUM_SHOTS       = 4,
  parameter int          SHOT_W          = 4,
  parameter int          SHOT_H          = 12,
  parameter int          SHOT_VEL        = 8,
  parameter int          COOLDOWN_FRAMES = 10,
  parameter logic [23:0] SHOT_COLOR      = 24'hFFFF00,
  parameter int          HRES            = 1280,
  parameter int          VRES            = 720,
  parameter int          PADDLE_H        = 16
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               fsync,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  input  logic               fire,
  input  logic [11:0]        paddle_center_x,
  input  logic               hit,
  output logic [7:0]         pixel [0:2],
  output logic               active,
  output logic               shot_fired,
  output logic [3:0]         shots_live
);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 2);
  localparam logic signed [11:0] Y0   = 12'(VRES - PADDLE_H - SHOT_H);
  localparam logic signed [12:0] XMAX = 13'(HRES - SHOT_W);
  logic [NUM_SHOTS-1:0] r_live, r_kill, w_in, w_sel, w_live_nxt;
  logic [11:0]          r_x [NUM_SHOTS];
  logic signed [11:0]   r_y [NUM_SHOTS];
  logic [CW-1:0]        r_cool;
  logic [3:0]           r_sync;
  logic                 r_fire_req, r_fired, w_launch;
  logic [3:0]           r_cnt;
  logic signed [12:0]   w_cx;
  logic [11:0]          w_xl;
  logic signed [13:0]   w_h, w_v;
  assign w_h  = {{2{hpos[11]}}, hpos};
  assign w_v  = {{2{vpos[11]}}, vpos};
  assign w_cx = $signed({1'b0, paddle_center_x}) - $signed(13'(SHOT_W / 2));
  assign w_xl = w_cx[12] ? 12'd0 : (w_cx > XMAX ? XMAX[11:0] : w_cx[11:0]);
  // Slots freed by this fsync's retire/move stay unusable until the next frame.
  always_comb begin
    w_sel = '0;
    for (int i = NUM_SHOTS - 1; i >= 0; i--) if (!r_live[i]) w_sel = NUM_SHOTS'(1) << i;
  end
  assign w_launch = r_fire_req && r_cool == '0 && |w_sel;
  for (genvar i = 0; i < NUM_SHOTS; i++) begin : g_box
    logic signed [13:0] w_l, w_t;
    assign w_l = {2'b00, r_x[i]};
    assign w_t = {{2{r_y[i][11]}}, r_y[i]};
    assign w_in[i] = r_live[i] && w_h >= w_l && w_h < w_l + 14'(SHOT_W)
                     && w_v >= w_t && w_v < w_t + 14'(SHOT_H);
    assign w_live_nxt[i] = (w_launch && w_sel[i])
                           || (r_live[i] && !r_kill[i] && r_y[i] >= 12'(SHOT_VEL));
  end
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_live     <= '0;
      r_kill     <= '0;
      r_cool     <= '0;
      r_sync     <= '0;
      r_fire_req <= 1'b0;
      r_fired    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync     <= {r_sync[2:0], fire};
      r_fire_req <= fsync ? 1'b0 : (r_fire_req | (r_sync[2] & ~r_sync[3]));
      r_fired    <= fsync && w_launch;
      if (fsync) begin
        r_live <= w_live_nxt;
        r_kill <= '0;
        r_cool <= w_launch ? CW'(COOLDOWN_FRAMES) : (r_cool != '0 ? r_cool - CW'(1) : r_cool);
        r_cnt  <= 4'($countones(w_live_nxt));
      end else if (hit) r_kill <= r_kill | w_in;
    end
  end
  // Position registers need no reset: the live bits gate every use of them.
  always_ff @(posedge pixel_clk) begin
    if (fsync)
      for (int i = 0; i < NUM_SHOTS; i++)
        if (w_launch && w_sel[i]) begin
          r_x[i] <= w_xl;
          r_y[i] <= Y0;
        end else if (r_y[i] >= 12'(SHOT_VEL)) r_y[i] <= r_y[i] - 12'(SHOT_VEL);
  end
  assign active     = |w_in;
  assign shot_fired = r_fired;
  assign shots_live = r_cnt;
  assign pixel[2]   = active ? SHOT_COLOR[23:16] : 8'h00;
  assign pixel[1]   = active ? SHOT_COLOR[15:8]  : 8'h00;
  assign pixel[0]   = active ? SHOT_COLOR[7:0]   : 8'h00;
endmodule

// File: tb/tb_player_shot.sv
// tb_player_shot: vector table, directed corner sequences and randomized frames
// checked against a slot-list model of the shot engine.
`timescale 1ns/1ps
module tb_player_shot;
  logic clk = 0, rst = 1, fsync = 0, fire = 0, hit = 0;
  logic signed [11:0] hpos = 0, vpos = 0;
  logic [11:0] center = 0;
  logic [7:0] pixel [0:2];
  logic active, shot_fired;
  logic [3:0] shots_live;
  int n_cmp = 0, n_bad = 0;
  int m_live[4], m_kill[4], m_x[4], m_y[4];
  int m_cool;
  bit m_req;
  typedef struct { int center; int exp_x; } vec_t;
  vec_t tbl[8];
  always #5 clk = ~clk;
  player_shot dut (
    .pixel_clk(clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos), .fire(fire),
    .paddle_center_x(center), .hit(hit), .pixel(pixel), .active(active),
    .shot_fired(shot_fired), .shots_live(shots_live)
  );
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic bit m_in(int i, int h, int v);
    return m_live[i] != 0 && h >= m_x[i] && h < m_x[i] + 4 && v >= m_y[i] && v < m_y[i] + 12;
  endfunction
  function automatic int m_count();
    int c = 0;
    foreach (m_live[i]) c += m_live[i];
    return c;
  endfunction
  task automatic do_reset;
    rst = 1;
    tick;
    rst = 0;
    foreach (m_live[i]) begin
      m_live[i] = 0;
      m_kill[i] = 0;
    end
    m_cool = 0;
    m_req = 0;
  endtask
  task automatic press;
    fire = 1;
    repeat (5) tick;
    fire = 0;
    repeat (4) tick;
    m_req = 1;
  endtask
  task automatic hit_at(int h, int v);
    hpos = 12'(h);
    vpos = 12'(v);
    hit = 1;
    tick;
    hit = 0;
    foreach (m_live[i]) if (m_in(i, h, v)) m_kill[i] = 1;
  endtask
  task automatic probe(string name, int h, int v, int exp);
    hpos = 12'(h);
    vpos = 12'(v);
    #1;
    chk(name, active, exp);
    chk({name, "_rgb"}, {pixel[2], pixel[1], pixel[0]}, exp != 0 ? 'hFFFF00 : 0);
    tick;
  endtask
  task automatic probe_m(string name, int h, int v);
    int e = 0;
    foreach (m_live[i]) if (m_in(i, h, v)) e = 1;
    probe(name, h, v, e);
  endtask
  task automatic fsync_chk(string name, int exp_f, bit with_hit, output int got_f);
    int idx = -1, x;
    bit launch;
    fsync = 1;
    hit = with_hit;
    tick;
    fsync = 0;
    hit = 0;
    foreach (m_live[i]) if (m_live[i] == 0 && idx < 0) idx = i;
    launch = m_req && m_cool == 0 && idx >= 0;
    foreach (m_live[i]) begin
      if (m_live[i] != 0) begin
        if (m_kill[i] != 0) m_live[i] = 0;
        else if (m_y[i] >= 8) m_y[i] -= 8;
        else m_live[i] = 0;
      end
      m_kill[i] = 0;
    end
    if (launch) begin
      x = int'(center) - 2;
      m_live[idx] = 1;
      m_x[idx] = x < 0 ? 0 : (x > 1276 ? 1276 : x);
      m_y[idx] = 692;
      m_cool = 10;
    end else if (m_cool > 0) m_cool--;
    m_req = 0;
    got_f = shot_fired;
    chk({name, "_fired"}, shot_fired, launch);
    chk({name, "_live"}, shots_live, m_count());
    if (exp_f >= 0) chk({name, "_fired_exp"}, shot_fired, exp_f);
    tick;
    chk({name, "_pulse_end"}, shot_fired, 0);
  endtask
  task automatic fs(string name);
    int g;
    fsync_chk(name, -1, 0, g);
  endtask
  task automatic pick(output int h, output int v);
    int q[$];
    foreach (m_live[i]) if (m_live[i] != 0) q.push_back(i);
    if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
      int i = q[$urandom_range(0, q.size() - 1)];
      h = m_x[i] + int'($urandom_range(0, 3));
      v = m_y[i] + int'($urandom_range(0, 11));
    end else begin
      h = int'($urandom_range(0, 1279));
      v = int'($urandom_range(0, 719));
    end
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int g, n, hx, hy, h, v;
    tbl[0] = '{640, 638};  tbl[1] = '{1, 0};     tbl[2] = '{0, 0};     tbl[3] = '{1279, 1276};
    tbl[4] = '{2, 0};      tbl[5] = '{3, 1};     tbl[6] = '{1278, 1276}; tbl[7] = '{1277, 1275};
    do_reset;
    chk("rst_active", active, 0);
    chk("rst_live", shots_live, 0);
    chk("rst_fired", shot_fired, 0);
    chk("rst_rgb", {pixel[2], pixel[1], pixel[0]}, 0);
    foreach (tbl[k]) begin
      do_reset;
      center = 12'(tbl[k].center);
      press;
      fsync_chk("tbl", 1, 0, g);
      chk("tbl_live1", shots_live, 1);
      probe("tbl_tl", tbl[k].exp_x, 692, 1);
      probe("tbl_br", tbl[k].exp_x + 3, 703, 1);
      probe("tbl_left", tbl[k].exp_x - 1, 692, 0);
      probe("tbl_right", tbl[k].exp_x + 4, 692, 0);
      probe("tbl_above", tbl[k].exp_x, 691, 0);
      probe("tbl_below", tbl[k].exp_x, 704, 0);
    end
    do_reset;
    center = 640;
    press;
    fs("t2_launch");
    repeat (84) fs("t2_fly");
    probe("t2_y20", 638, 20, 1);
    probe("t2_y19", 638, 19, 0);
    fs("t2_a");
    probe("t2_y12", 638, 12, 1);
    probe("t2_y24", 638, 24, 0);
    fs("t2_b");
    probe("t2_y4", 638, 4, 1);
    probe("t2_neg", 638, -4, 0);
    probe("t2_y16", 638, 16, 0);
    fs("t2_c");
    chk("t2_retired", shots_live, 0);
    probe("t2_gone0", 638, 0, 0);
    probe("t2_gone_neg", 638, -4, 0);
    do_reset;
    n = 0;
    for (int f = 0; f < 30; f++) begin
      press;
      fsync_chk("t3", (f % 11 == 0) ? 1 : 0, 0, g);
      n += g;
    end
    chk("t3_count", n, 3);
    chk("t3_live", shots_live, 3);
    do_reset;
    fire = 1;
    n = 0;
    for (int f = 0; f < 30; f++) begin
      repeat (6) tick;
      if (f == 0) m_req = 1;
      fsync_chk("t3h", -1, 0, g);
      n += g;
    end
    fire = 0;
    chk("t3h_count", n, 1);
    do_reset;
    center = 640;
    for (int f = 0; f < 34; f++) begin
      if (f % 11 == 0) press;
      fs("t5_fill");
    end
    chk("t5_full", shots_live, 4);
    repeat (11) fs("t5_wait");
    press;
    hit_at(m_x[2] + 1, m_y[2] + 5);
    fsync_chk("t5_blocked", 0, 0, g);
    chk("t5_after_hit", shots_live, 3);
    center = 100;
    press;
    fsync_chk("t5_reuse", 1, 0, g);
    chk("t5_refill", shots_live, 4);
    probe("t5_new", 98, 692, 1);
    do_reset;
    center = 640;
    for (int f = 0; f < 28; f++) begin
      if (f % 11 == 0) press;
      fs("t6_fill");
    end
    chk("t6_pre_live", shots_live, 3);
    hx = m_x[0];
    hy = m_y[0];
    tick;
    tick;
    do_reset;
    chk("t6_live", shots_live, 0);
    chk("t6_fired", shot_fired, 0);
    probe("t6_active", hx, hy, 0);
    press;
    fsync_chk("t6_relaunch", 1, 0, g);
    chk("t6_live1", shots_live, 1);
    do_reset;
    center = 640;
    press;
    fs("fh_launch");
    hpos = 639;
    vpos = 695;
    fsync_chk("fh", -1, 1, g);
    fs("fh_next");
    chk("fh_survive", shots_live, 1);
    do_reset;
    for (int f = 0; f < 150; f++) begin
      center = 12'($urandom_range(0, 1279));
      if ($urandom_range(0, 2) == 0) press;
      repeat (3) begin
        pick(h, v);
        probe_m("rnd_px", h, v);
      end
      if ($urandom_range(0, 3) == 0) begin
        pick(h, v);
        hit_at(h, v);
      end
      fs("rnd");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
